mm_row_collector: RTL
=====================

# mm_row_collector

Downstream stage of the `MM` matrix-multiply core. Captures MM's non-stallable result stream (`valid`, `out_data`, `overflow`, `change_row`, `is_legal`, `ep`) into a two-bank row buffer. Re-emits each completed row on a ready/valid stream toward the result writer. Absorbs one row of downstream back-pressure, flags drops and over-long rows, and emits a single status record for illegal or unmultipliable matrix pairs.

## Interface

Parameters:
- `MAX_COL`, default 8: maximum entries per row; sets the depth of each bank.
- `COL_W`, default 4: width of the column index. Requirement: `MAX_COL <= 2**COL_W - 1`.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `mm_valid`, in, 1: MM result beat present (MM `valid`).
- `mm_data`, in, 12: MM `out_data`.
- `mm_overflow`, in, 1: MM `overflow` for this beat.
- `mm_change_row`, in, 1: this beat is the last entry of its row.
- `mm_is_legal`, in, 1: 0 means no product exists; the beat is a status beat.
- `mm_ep`, in, 2: MM error/shape code.
- `out_valid`, out, 1: output record available.
- `out_ready`, in, 1: downstream accepts the record.
- `out_data`, out, 12: entry value.
- `out_ovf`, out, 1: entry overflowed.
- `out_last`, out, 1: last record of the row.
- `out_idx`, out, `COL_W`: column index within the row.
- `out_illegal`, out, 1: status record (no product).
- `out_ep`, out, 2: `mm_ep` captured with the row.
- `drop_err`, out, 1: sticky; a beat was dropped because no bank was free.
- `len_err`, out, 1: sticky; row overrun or partial row discarded.
- `err_clr`, in, 1: synchronous clear of both sticky flags.

## Operation

Storage:
- Two banks, each holding `MAX_COL` x {data 12, ovf 1}, plus per-bank length, `illegal`, `ep` and a `full` flag.
- `wr_bank` and `rd_bank` pointers toggle 0/1.
- Write FSM states: IDLE (no partial row), FILL (partial row open), SKIP (overrun; discarding until `mm_change_row`).

Legal beat (`mm_valid & mm_is_legal`):
- If `full[wr_bank]`: drop the beat and set `drop_err`. A closing beat that is dropped discards the whole row.
- Otherwise, if `wr_cnt < MAX_COL`: store at `wr_cnt` and increment. `ep` is latched on the first beat.
- If `wr_cnt == MAX_COL`: go to SKIP and set `len_err`.
- On `mm_change_row`, in FILL or SKIP: the row closes. Set `len = wr_cnt` (count including this beat, capped at `MAX_COL`), set `full[wr_bank]`, toggle `wr_bank`, clear `wr_cnt`, go to IDLE.

Status beat (`mm_valid & ~mm_is_legal`):
- Any open partial row is discarded and `len_err` is set.
- If a bank is free, write one record: data 0, ovf 0, `illegal=1`, `ep=mm_ep`, len 1, and mark the bank full.
- `mm_change_row` is ignored on status beats.

Read side:
- `out_valid = full[rd_bank]`.
- Outputs are driven from bank `rd_bank` at `rd_cnt`; `out_idx = rd_cnt`.
- `out_last` is asserted when `rd_cnt == len-1`.
- On handshake, `rd_cnt` increments. On the last record, clear `full[rd_bank]`, toggle `rd_bank`, and clear `rd_cnt`.

Simultaneity and flags:
- A read freeing a bank and a write closing the other bank in the same cycle are both performed.
- A write into the bank being freed in that same cycle is dropped; a free bank becomes writable the following cycle.
- `err_clr` clears the sticky flags. A new error event in the same cycle wins.

## Timing

- Reset values: `out_valid`=0, `out_data`=0, `out_ovf`=0, `out_last`=0, `out_idx`=0, `out_illegal`=0, `out_ep`=0, `drop_err`=0, `len_err`=0. Pointers, counters and `full` flags are 0; write FSM is IDLE.
- Reset mid-row discards all buffered and partial data.
- Latency: the closing beat is captured at edge N; `out_valid` is high after edge N and the first record is presented in cycle N+1.
- Throughput: one record per cycle while `out_ready=1`. Input accepts one beat every cycle with no stall path.
- `out_*` stay stable while `out_valid & ~out_ready`.

## Configuration

- `MMRC_SAT_EN` defined: an entry stored with ovf=1 is presented as `out_data = 12'hFFF`.
- `MMRC_SAT_EN` undefined: raw `mm_data` is presented.
- `out_ovf` reflects the stored overflow bit in both builds.

## Test plan

- Row of beats 5, 7, 9 with `change_row` on 9, `out_ready`=1 -> from cycle N+1 the outputs are 5/idx0, 7/idx1, 9/idx2 with `last`=1; `out_ep` equals the captured `mm_ep`.
- Beat `12'h123` with ovf=1 -> `out_data=12'hFFF`, `out_ovf=1` when `MMRC_SAT_EN` is defined; `12'h123`, `out_ovf=1` when undefined.
- `out_ready`=0, three 2-entry rows arrive -> `drop_err`=1. After raising `out_ready`, rows 1 and 2 are emitted in order and row 3 never appears.
- Status beat with `ep=2'b10` -> one record with `illegal=1`, `ep=2`, `last=1`, data 0.
- 9 beats with `MAX_COL=8`, `change_row` on the 9th -> 8 records, idx 0..7, `last` on idx 7, `len_err=1`. Then `err_clr` -> `len_err=0`.
- Reset asserted after 2 beats of a row -> all outputs 0 immediately. The next full row is emitted starting at idx 0.

Source files
------------

// File: rtl/mm_row_collector_if.sv
// rtl/mm_row_collector_if.sv - MM result stream, row record stream and error flags of mm_row_collector
//
// Signals:
//   mm_valid/mm_data/mm_overflow/mm_change_row/mm_is_legal/mm_ep : MM result beats (no stall path)
//   out_valid/out_ready/out_data/out_ovf/out_last/out_idx/out_illegal/out_ep : row records
//   drop_err/len_err : sticky error flags, err_clr : synchronous clear of both flags
// Modports:
//   master : environment side (drives MM beats, out_ready and err_clr)
//   slave  : collector side
interface mm_row_collector_if #(
    parameter int COL_W = 4
);
    logic             mm_valid;
    logic [11:0]      mm_data;
    logic             mm_overflow;
    logic             mm_change_row;
    logic             mm_is_legal;
    logic [1:0]       mm_ep;

    logic             out_valid;
    logic             out_ready;
    logic [11:0]      out_data;
    logic             out_ovf;
    logic             out_last;
    logic [COL_W-1:0] out_idx;
    logic             out_illegal;
    logic [1:0]       out_ep;

    logic             drop_err;
    logic             len_err;
    logic             err_clr;

    modport master (
        output mm_valid, mm_data, mm_overflow, mm_change_row, mm_is_legal, mm_ep,
        output out_ready, err_clr,
        input  out_valid, out_data, out_ovf, out_last, out_idx, out_illegal, out_ep,
        input  drop_err, len_err
    );

    modport slave (
        input  mm_valid, mm_data, mm_overflow, mm_change_row, mm_is_legal, mm_ep,
        input  out_ready, err_clr,
        output out_valid, out_data, out_ovf, out_last, out_idx, out_illegal, out_ep,
        output drop_err, len_err
    );
endinterface

// File: rtl/mm_row_collector.sv
// rtl/mm_row_collector.sv - two-bank row buffer between the MM core and the result writer
//
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : mm_row_collector_if.slave (MM beats in, row records out, sticky error flags)
// Parameters:
//   MAX_COL : entries per row / bank depth, COL_W : column index width (MAX_COL <= 2**COL_W - 1)
// Build option:
//   MMRC_SAT_EN : when defined, entries stored with overflow are presented as 12'hFFF
module mm_row_collector #(
    parameter int MAX_COL = 8,
    parameter int COL_W   = 4
) (
    input logic              clk,
    input logic              rst,
    mm_row_collector_if.slave bus
);
    localparam int              IDX_W   = (MAX_COL > 1) ? $clog2(MAX_COL) : 1;
    localparam logic [COL_W-1:0] MAX_CNT = COL_W'(MAX_COL);
    localparam logic [COL_W-1:0] ONE     = COL_W'(1);

    typedef enum logic [1:0] {
        W_IDLE,
        W_FILL,
        W_SKIP
    } wst_e;

    logic [11:0]      mem_data_q [2][MAX_COL];
    logic             mem_ovf_q  [2][MAX_COL];
    logic [COL_W-1:0] len_q      [2];
    logic             ill_q      [2];
    logic [1:0]       ep_q       [2];
    logic [1:0]       full_q;

    logic             wr_bank_q;
    logic             rd_bank_q;
    logic [COL_W-1:0] wr_cnt_q;
    logic [COL_W-1:0] rd_cnt_q;
    wst_e             wst_q;
    logic             drop_err_q;
    logic             len_err_q;

    logic [IDX_W-1:0] rd_ptr;
    logic [IDX_W-1:0] wr_ptr;
    logic [11:0]      rd_data;
    logic             rd_ovf;
    logic             rd_last;
    logic             rd_fire;
    logic             wr_room;

    // Counters are COL_W wide but banks only need IDX_W address bits.
    assign rd_ptr  = rd_cnt_q[IDX_W-1:0];
    assign wr_ptr  = wr_cnt_q[IDX_W-1:0];
    assign rd_data = mem_data_q[rd_bank_q][rd_ptr];
    assign rd_ovf  = mem_ovf_q[rd_bank_q][rd_ptr];
    assign rd_last = (rd_cnt_q == (len_q[rd_bank_q] - ONE));
    assign rd_fire = full_q[rd_bank_q] & bus.out_ready;
    assign wr_room = (wr_cnt_q < MAX_CNT);

    assign bus.out_valid   = full_q[rd_bank_q];
`ifdef MMRC_SAT_EN
    assign bus.out_data    = rd_ovf ? 12'hFFF : rd_data;
`else
    assign bus.out_data    = rd_data;
`endif
    assign bus.out_ovf     = rd_ovf;
    assign bus.out_last    = rd_last;
    assign bus.out_idx     = rd_cnt_q;
    assign bus.out_illegal = ill_q[rd_bank_q];
    assign bus.out_ep      = ep_q[rd_bank_q];
    assign bus.drop_err    = drop_err_q;
    assign bus.len_err     = len_err_q;

    // Read and write sides share one block. They never touch the same full_q bit in
    // one cycle: the write side only claims a bank whose full bit is currently clear,
    // the read side only releases one whose bit is currently set. A bank released this
    // cycle therefore cannot be written until the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < MAX_COL; i++) begin
                    mem_data_q[b][i] <= '0;
                    mem_ovf_q[b][i]  <= 1'b0;
                end
                len_q[b] <= '0;
                ill_q[b] <= 1'b0;
                ep_q[b]  <= '0;
            end
            full_q     <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            wst_q      <= W_IDLE;
            drop_err_q <= 1'b0;
            len_err_q  <= 1'b0;
        end else begin
            // Clear first so a same-cycle error event below overrides it.
            if (bus.err_clr) begin
                drop_err_q <= 1'b0;
                len_err_q  <= 1'b0;
            end

            if (rd_fire) begin
                if (rd_last) begin
                    full_q[rd_bank_q] <= 1'b0;
                    rd_bank_q         <= ~rd_bank_q;
                    rd_cnt_q          <= '0;
                end else begin
                    rd_cnt_q <= rd_cnt_q + ONE;
                end
            end

            if (bus.mm_valid && bus.mm_is_legal) begin
                if (full_q[wr_bank_q]) begin
                    // Both banks occupied; a partial row cannot exist here, so a
                    // dropped closing beat just leaves the writer idle.
                    drop_err_q <= 1'b1;
                    if (bus.mm_change_row) begin
                        wr_cnt_q <= '0;
                        wst_q    <= W_IDLE;
                    end
                end else begin
                    if (wr_room) begin
                        mem_data_q[wr_bank_q][wr_ptr] <= bus.mm_data;
                        mem_ovf_q[wr_bank_q][wr_ptr]  <= bus.mm_overflow;
                        wr_cnt_q <= wr_cnt_q + ONE;
                        if (wr_cnt_q == '0) begin
                            ep_q[wr_bank_q]  <= bus.mm_ep;
                            ill_q[wr_bank_q] <= 1'b0;
                        end
                        wst_q <= W_FILL;
                    end else begin
                        // Row longer than a bank: keep the first MAX_COL entries.
                        len_err_q <= 1'b1;
                        wst_q     <= W_SKIP;
                    end
                    if (bus.mm_change_row) begin
                        len_q[wr_bank_q]  <= wr_room ? (wr_cnt_q + ONE) : MAX_CNT;
                        full_q[wr_bank_q] <= 1'b1;
                        wr_bank_q         <= ~wr_bank_q;
                        wr_cnt_q          <= '0;
                        wst_q             <= W_IDLE;
                    end
                end
            end else if (bus.mm_valid) begin
                // Status beat: abandons any open row and becomes a one-record row.
                if (wst_q != W_IDLE) begin
                    len_err_q <= 1'b1;
                end
                wr_cnt_q <= '0;
                wst_q    <= W_IDLE;
                if (!full_q[wr_bank_q]) begin
                    mem_data_q[wr_bank_q][0] <= '0;
                    mem_ovf_q[wr_bank_q][0]  <= 1'b0;
                    ill_q[wr_bank_q]         <= 1'b1;
                    ep_q[wr_bank_q]          <= bus.mm_ep;
                    len_q[wr_bank_q]         <= ONE;
                    full_q[wr_bank_q]        <= 1'b1;
                    wr_bank_q                <= ~wr_bank_q;
                end else begin
                    drop_err_q <= 1'b1;
                end
            end
        end
    end
endmodule
